calc_bcd_converter: RTL and testbench

Sequential post-processing stage directly downstream of the 6-bit four-function calculator. It captures one calculator result per request, selected by operation code, and resolves its sign. It converts the magnitude to four packed BCD digits using a 12-iteration shift-add-3 (double-dabble) engine, one iteration per clock. It flags division by zero and presents a stable, registered result for the display stage, with a one-cycle completion pulse.

---
 rtl/calc_bcd_converter.sv | 113 +++++++++++
 tb/tb_calc_bcd_converter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_bcd_converter.sv
// Captures one calculator result, resolves its sign and converts the magnitude
// to four packed BCD digits with a 12-step shift-add-3 engine.
module calc_bcd_converter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [6:0]  i_add,
  input  logic [6:0]  i_sub,
  input  logic [11:0] i_mul,
  input  logic [5:0]  i_div,
  input  logic [5:0]  i_data2,
  output logic [15:0] o_bcd,
  output logic        o_neg,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, CONV, ERR} state_t;

  state_t      state_reg;
  logic [3:0]  iter_reg;
  logic [11:0] bin_reg;
  logic [15:0] bcd_reg;
  logic        sign_reg;

  logic [15:0] bcd_adj;
  logic [27:0] shift_next;
  logic [6:0]  sub_mag;
  logic [11:0] mag_sel;
  logic        sign_sel;
  logic        div_zero;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // The magnitude of the adjusted BCD plus binary shifts as one 28-bit word.
  assign shift_next = {bcd_adj, bin_reg} << 1;

  always_comb begin
    sub_mag  = i_sub[6] ? (~i_sub + 7'd1) : i_sub;
    sign_sel = (i_op == 2'b01) && i_sub[6];
    div_zero = (i_op == 2'b11) && (i_data2 == 6'd0);
    case (i_op)
      2'b00:   mag_sel = {5'd0, i_add};
      2'b01:   mag_sel = {5'd0, sub_mag};
      2'b10:   mag_sel = i_mul;
      default: mag_sel = {6'd0, i_div};
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      iter_reg  <= 4'd0;
      bin_reg   <= 12'd0;
      bcd_reg   <= 16'd0;
      sign_reg  <= 1'b0;
      o_bcd     <= 16'h0000;
      o_neg     <= 1'b0;
      o_err     <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            o_busy <= 1'b1;
            if (div_zero) begin
              state_reg <= ERR;
            end else begin
              state_reg <= CONV;
              bin_reg   <= mag_sel;
              bcd_reg   <= 16'd0;
              sign_reg  <= sign_sel;
              iter_reg  <= 4'd0;
            end
          end
        end
        CONV: begin
          bcd_reg  <= shift_next[27:12];
          bin_reg  <= shift_next[11:0];
          iter_reg <= iter_reg + 4'd1;
          if (iter_reg == 4'd11) begin
            state_reg <= IDLE;
            iter_reg  <= 4'd0;
            o_bcd     <= shift_next[27:12];
            o_neg     <= sign_reg;
            o_err     <= 1'b0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
          end
        end
        ERR: begin
          state_reg <= IDLE;
          o_bcd     <= 16'h0000;
          o_neg     <= 1'b0;
          o_err     <= 1'b1;
          o_done    <= 1'b1;
          o_busy    <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_bcd_converter.sv
// Scoreboard bench: a cycle-level acceptance model pushes decimal reference
// results; a negedge monitor checks handshakes, holds and completions.
module tb_calc_bcd_converter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [6:0]  i_add = 7'd0;
  logic [6:0]  i_sub = 7'd0;
  logic [11:0] i_mul = 12'd0;
  logic [5:0]  i_div = 6'd0;
  logic [5:0]  i_data2 = 6'd0;
  logic [15:0] o_bcd;
  logic        o_neg;
  logic        o_err;
  logic        o_busy;
  logic        o_done;

  calc_bcd_converter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
    .i_add(i_add), .i_sub(i_sub), .i_mul(i_mul), .i_div(i_div),
    .i_data2(i_data2), .o_bcd(o_bcd), .o_neg(o_neg), .o_err(o_err),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          rem = 0;
  logic        done_exp = 1'b0;
  logic [17:0] held = 18'd0;
  logic [17:0] exp_q[$];

  // Reference result {bcd, neg, err} from decimal arithmetic.
  function automatic logic [17:0] ref_result(input logic [1:0] op, input logic [6:0] a,
      input logic [6:0] s, input logic [11:0] m, input logic [5:0] d, input logic [5:0] d2);
    int mag;
    logic neg;
    logic [15:0] b;
    neg = 1'b0;
    if (op == 2'd3 && d2 == 6'd0) return {16'h0000, 1'b0, 1'b1};
    case (op)
      2'd0: mag = int'(a);
      2'd1: begin
        mag = int'($signed(s));
        if (mag < 0) begin neg = 1'b1; mag = -mag; end
      end
      2'd2: mag = int'(m);
      default: mag = int'(d);
    endcase
    b = {4'(mag / 1000 % 10), 4'(mag / 100 % 10), 4'(mag / 10 % 10), 4'(mag % 10)};
    return {b, neg, 1'b0};
  endfunction

  // Acceptance model: busy for 12 cycles (1 on divide-by-zero), start ignored while busy.
  always @(posedge i_clk) begin
    if (i_rst) begin
      rem = 0;
      done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) done_exp = 1'b1;
      end else if (i_start) begin
        exp_q.push_back(ref_result(i_op, i_add, i_sub, i_mul, i_div, i_data2));
        rem = (i_op == 2'd3 && i_data2 == 6'd0) ? 1 : 12;
      end
    end
  end

  always @(posedge i_rst) begin
    exp_q.delete();
    rem = 0;
    done_exp = 1'b0;
    held = 18'd0;
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      n_vec++;
      if (o_busy !== (rem != 0) || o_done !== done_exp) begin
        n_bad++;
        $display("FAIL handshake: busy=%0b done=%0b, required busy=%0b done=%0b",
                 o_busy, o_done, (rem != 0), done_exp);
      end
      if (o_done) begin
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: bcd=%h with no request outstanding", o_bcd);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          n_vec++;
          if ({o_bcd, o_neg, o_err} !== e) begin
            n_bad++;
            $display("FAIL result: bcd=%h neg=%0b err=%0b, required bcd=%h neg=%0b err=%0b",
                     o_bcd, o_neg, o_err, e[17:2], e[1], e[0]);
          end else begin
            $display("result bcd=%h neg=%0b err=%0b", o_bcd, o_neg, o_err);
          end
          held = e;
        end
      end else begin
        n_vec++;
        if ({o_bcd, o_neg, o_err} !== held) begin
          n_bad++;
          $display("FAIL hold: bcd=%h neg=%0b err=%0b, required bcd=%h neg=%0b err=%0b",
                   o_bcd, o_neg, o_err, held[17:2], held[1], held[0]);
        end
      end
    end
  end

  task automatic scramble();
    i_op    = 2'($urandom);
    i_add   = 7'($urandom);
    i_sub   = 7'($urandom);
    i_mul   = 12'($urandom);
    i_div   = 6'($urandom);
    i_data2 = 6'($urandom);
  endtask

  task automatic req(input logic [1:0] op, input logic [6:0] a, input logic [6:0] s,
                     input logic [11:0] m, input logic [5:0] d, input logic [5:0] d2);
    @(negedge i_clk);
    i_op = op; i_add = a; i_sub = s; i_mul = m; i_div = d; i_data2 = d2;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && (rem != 0 || exp_q.size() != 0); k++) @(negedge i_clk);
    if (rem != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout: %0d results still outstanding", exp_q.size());
      exp_q.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if ({o_bcd, o_neg, o_err, o_busy, o_done} !== 20'd0) begin
      n_bad++;
      $display("FAIL %s: bcd=%h neg=%0b err=%0b busy=%0b done=%0b, required all zero",
               name, o_bcd, o_neg, o_err, o_busy, o_done);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1 check_zero("reset_state");
    @(negedge i_clk);
    #2 i_rst = 1'b0;

    req(2'd0, 7'd126, 7'd0, 12'd0, 6'd0, 6'd1);         wait_idle();
    req(2'd1, 7'd0, 7'b1111100, 12'd0, 6'd0, 6'd1);     wait_idle();
    req(2'd1, 7'd0, 7'b1000001, 12'd0, 6'd0, 6'd1);     wait_idle();
    req(2'd1, 7'd0, 7'd0, 12'd0, 6'd0, 6'd1);           wait_idle();
    req(2'd1, 7'd0, 7'd63, 12'd0, 6'd0, 6'd1);          wait_idle();
    req(2'd2, 7'd0, 7'd0, 12'd3969, 6'd0, 6'd1);        wait_idle();
    req(2'd2, 7'd0, 7'd0, 12'd0, 6'd0, 6'd1);           wait_idle();
    req(2'd3, 7'd0, 7'd0, 12'd0, 6'd37, 6'd0);          wait_idle();
    req(2'd3, 7'd0, 7'd0, 12'd0, 6'd9, 6'd7);           wait_idle();

    // Second start during a mul conversion must be dropped.
    req(2'd2, 7'd0, 7'd0, 12'd1234, 6'd0, 6'd1);
    repeat (3) @(negedge i_clk);
    i_op = 2'd0; i_add = 7'd55; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_idle();

    // Start held high restarts every time the converter returns to idle.
    @(negedge i_clk);
    i_op = 2'd2; i_mul = 12'd2048; i_start = 1'b1;
    repeat (30) @(negedge i_clk);
    i_op = 2'd3; i_data2 = 6'd0;
    repeat (6) @(negedge i_clk);
    i_start = 1'b0;
    wait_idle();

    // Asynchronous reset between edges mid-conversion.
    req(2'd2, 7'd0, 7'd0, 12'd3969, 6'd0, 6'd1);
    repeat (5) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_zero("async_reset");
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    req(2'd0, 7'd99, 7'd0, 12'd0, 6'd0, 6'd1);          wait_idle();

    for (int n = 0; n < 150; n++) begin
      logic [1:0]  op;
      logic [6:0]  a, s;
      logic [11:0] m;
      logic [5:0]  d, d2;
      op = 2'($urandom);
      a  = 7'($urandom_range(0, 126));
      s  = 7'(int'($urandom_range(0, 126)) - 63);
      m  = 12'($urandom_range(0, 63) * $urandom_range(0, 63));
      d  = 6'($urandom);
      d2 = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      req(op, a, s, m, d, d2);
      if ($urandom_range(0, 1) == 1) wait_idle();
      else for (int k = 0; k < 40 && rem != 0; k++) @(negedge i_clk);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
